uart_rx: RTL and testbench

// - UART serial receiver; the stage directly upstream of the byte FIFO.
// - Deserialises an asynchronous 8N1 line and drives the FIFO write side with a

---
 rtl/uart_rx.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 (optionally 8E1/8O1) UART receiver feeding the byte FIFO.
// Ports: clk, rst (sync, active-high), rx_in (async line, idle high),
//   fifo_full (sampled on write cycle); wr_data/wr_en drive the FIFO
//   write side; busy (not IDLE); frame_err, overrun, parity_err pulses.
// Config: define UART_RX_PARITY_EN to add a parity bit after the data
//   bits (sense from PARITY_ODD); otherwise parity_err is tied 0.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 fifo_full,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 wr_en,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
  logic                 wr_en_q, wr_en_d;
  logic                 busy_q, busy_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 bad_par;
  logic                 tick_half, tick_full;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic bad_par_q, bad_par_d;
  logic perr_q, perr_d;
  assign bad_par = bad_par_q;
`else
  logic perr_d;
  logic unused_par_odd;
  assign bad_par = 1'b0;
  // Parity sense has no meaning without a parity bit in the frame.
  assign unused_par_odd = (PARITY_ODD != 0);
`endif

  assign tick_half = (cnt_q == HALF_TC);
  assign tick_full = (cnt_q == FULL_TC);

  // Sync flops reset high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bad_par_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      bad_par_q <= bad_par_d;
      perr_q    <= perr_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    perr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    bad_par_d = bad_par_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
`ifdef UART_RX_PARITY_EN
        bad_par_d = 1'b0;
`endif
        if (!rx_s_q) state_d = START;
      end

      START: begin
        if (tick_half) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            // Low pulse shorter than half a bit: glitch.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (tick_full) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_full) begin
          cnt_d     = '0;
          bad_par_d = ((^shift_q) ^ rx_s_q) != PAR_ODD;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      STOP: begin
        if (tick_full) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end else if (bad_par) begin
            perr_d  = 1'b1;
            state_d = IDLE;
          end else if (fifo_full) begin
            ovr_d   = 1'b1;
            state_d = IDLE;
          end else begin
            wr_data_d = shift_q;
            wr_en_d   = 1'b1;
            state_d   = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT_IDLE: begin
        // Line must return high before another start bit is accepted.
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign wr_data   = wr_data_q;
  assign wr_en     = wr_en_q;
  assign busy      = busy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = perr_d;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at CLKS_PER_BIT=16.
// Counts output pulses on the falling edge and checks deltas per step.
module tb_uart_rx;

  localparam int C = 16;
  localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + H + 10 * C;
`else
  localparam int LAT = 2 + H + 9 * C;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic       fifo_full = 1'b0;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  uart_rx #(
    .CLKS_PER_BIT(C),
    .DATA_BITS(8),
    .PARITY_ODD(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_in(rx_in),
    .fifo_full(fifo_full),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .busy(busy),
    .frame_err(frame_err),
    .overrun(overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int n_wr = 0;
  int n_fe = 0;
  int n_ov = 0;
  int n_pe = 0;
  int n_fall = 0;
  int wr_cyc = 0;
  int start_cyc = 0;
  logic busy_prev = 1'b0;
  logic [7:0] last_wd = 8'h00;
`ifdef UART_RX_PARITY_EN
  logic bad_par_tx = 1'b0;
`endif

  always @(negedge clk) begin
    if (wr_en) begin
      n_wr++;
      wr_cyc = cyc;
      last_wd = wr_data;
    end
    if (frame_err) n_fe++;
    if (overrun) n_ov++;
    if (parity_err) n_pe++;
    if (busy_prev && !busy) n_fall++;
    busy_prev = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_for(input logic b, input int n);
    rx_in = b;
    repeat (n) @(negedge clk);
  endtask

  // Sends start, 8 data bits LSB first, [parity], then the given stop.
  task automatic send(input logic [7:0] d, input logic stop);
    start_cyc = cyc + 1;
    bit_for(1'b0, C);
    for (int i = 0; i < 8; i++) bit_for(d[i], C);
`ifdef UART_RX_PARITY_EN
    bit_for((^d) ^ bad_par_tx, C);
`endif
    bit_for(stop, C);
  endtask

  int w0, fe0, ov0, pe0, fl0, lat;

  initial begin
    @(negedge clk);
    rst = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_parity_err", {31'd0, parity_err}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single frame
    w0 = n_wr; fe0 = n_fe; ov0 = n_ov; pe0 = n_pe;
    send(8'hA5, 1'b1);
    repeat (C) @(negedge clk);
    chk("a5_writes", n_wr - w0, 1);
    chk("a5_data", {24'd0, wr_data}, 32'h A5);
    lat = wr_cyc - start_cyc;
    chk("a5_latency_in_window",
        {31'd0, (lat >= LAT - 1) && (lat <= LAT + 1)}, 1);
    chk("a5_no_errs", (n_fe - fe0) + (n_ov - ov0) + (n_pe - pe0), 0);
    chk("a5_busy_idle", {31'd0, busy}, 32'd0);

    // Back-to-back 0x00 then 0xFF
    w0 = n_wr; fl0 = n_fall; fe0 = n_fe;
    send(8'h00, 1'b1);
    chk("b2b_first_data", {24'd0, last_wd}, 32'h00);
    chk("b2b_first_write", n_wr - w0, 1);
    send(8'hFF, 1'b1);
    repeat (C) @(negedge clk);
    chk("b2b_writes", n_wr - w0, 2);
    chk("b2b_second_data", {24'd0, last_wd}, 32'hFF);
    chk("b2b_busy_falls", n_fall - fl0, 2);
    chk("b2b_no_ferr", n_fe - fe0, 0);

    // Framing error, stuck-low line, recovery
    w0 = n_wr; fe0 = n_fe;
    send(8'h3C, 1'b0);
    bit_for(1'b0, 40);
    chk("ferr_pulses", n_fe - fe0, 1);
    chk("ferr_no_write", n_wr - w0, 0);
    chk("ferr_busy_while_low", {31'd0, busy}, 32'd1);
    bit_for(1'b1, C);
    chk("ferr_busy_released", {31'd0, busy}, 32'd0);
    send(8'h3C, 1'b1);
    repeat (C) @(negedge clk);
    chk("recov_writes", n_wr - w0, 1);
    chk("recov_data", {24'd0, wr_data}, 32'h3C);
    chk("recov_ferr_total", n_fe - fe0, 1);

    // Overrun
    w0 = n_wr; ov0 = n_ov;
    fifo_full = 1'b1;
    send(8'h55, 1'b1);
    fifo_full = 1'b0;
    repeat (C) @(negedge clk);
    chk("ovr_pulses", n_ov - ov0, 1);
    chk("ovr_no_write", n_wr - w0, 0);
    chk("ovr_data_held", {24'd0, wr_data}, 32'h3C);

    // Glitch
    w0 = n_wr; fe0 = n_fe; ov0 = n_ov; pe0 = n_pe; fl0 = n_fall;
    bit_for(1'b0, 4);
    bit_for(1'b1, 2 * C);
    chk("glitch_flags",
        (n_wr - w0) + (n_fe - fe0) + (n_ov - ov0) + (n_pe - pe0), 0);
    chk("glitch_busy_seen", n_fall - fl0, 1);
    chk("glitch_busy_idle", {31'd0, busy}, 32'd0);

    // Reset mid-frame
    w0 = n_wr; fe0 = n_fe;
    bit_for(1'b0, C);
    bit_for(1'b1, C);
    bit_for(1'b0, C);
    rst = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (12 * C) @(negedge clk);
    chk("midrst_no_write", n_wr - w0, 0);
    chk("midrst_no_ferr", n_fe - fe0, 0);
    chk("midrst_idle", {31'd0, busy}, 32'd0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit is 1
    w0 = n_wr; pe0 = n_pe;
    bad_par_tx = 1'b0;
    send(8'h07, 1'b1);
    repeat (C) @(negedge clk);
    chk("par_good_write", n_wr - w0, 1);
    chk("par_good_data", {24'd0, wr_data}, 32'h07);
    chk("par_good_no_perr", n_pe - pe0, 0);
    w0 = n_wr;
    bad_par_tx = 1'b1;
    send(8'h07, 1'b1);
    bad_par_tx = 1'b0;
    repeat (C) @(negedge clk);
    chk("par_bad_perr", n_pe - pe0, 1);
    chk("par_bad_no_write", n_wr - w0, 0);
`else
    chk("no_parity_pulses", n_pe, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
